fpdiv: RTL and testbench
========================

# fpdiv

Iterative IEEE-754 single-precision divider, the companion to `fpmult` in the synth arithmetic datapath. It computes `dataa / datab` with a restoring shift-subtract loop, one quotient bit per clock, and rounds to nearest-even. It has a fixed latency regardless of operand values, so envelope and filter control logic can schedule around it.

## Interface
- No parameters. Format is fixed at binary32.
- `clk` input 1: system clock, rising-edge.
- `reset` input 1: asynchronous, active-high; aborts any operation in flight.
- `start` input 1: pulse high for one cycle to launch a division. Operands are captured on the same edge.
- `dataa` input 32: dividend, binary32.
- `datab` input 32: divisor, binary32.
- `result` output 32: quotient, binary32. Valid while `done` is high.
- `done` output 1: high from completion until the next accepted `start`.

## Operation
- States:
  - `IDLE`: accepts `start`.
  - `DIVIDE`: 26 cycles.
  - `ROUND`: 1 cycle.
  - `DONE`: holds the result and accepts `start`.
- `start` in `IDLE` or `DONE`:
  - latch sign, exponent and mantissa (hidden bit made explicit);
  - clear `done`;
  - classify the operands;
  - enter `DIVIDE` with the bit counter at 25.
- `start` in `DIVIDE` or `ROUND` is ignored and the operands are not re-latched.
- Input classes:
  - Exponent 0 means zero; denormals are flushed to zero.
  - Exponent 255 with mantissa 0 means infinity.
  - Exponent 255 with nonzero mantissa means NaN.
- Special results, by priority:
  1. Any NaN operand, 0/0 or inf/inf → `32'h7fc00000` (sign 0).
  2. inf/x or x/0 → signed infinity.
  3. 0/x or x/inf → signed zero.
- Sign is always `sa ^ sb` except for NaN.
- Special cases still run the full `DIVIDE`/`ROUND` sequence so latency stays fixed. The special flag overrides the result in `ROUND`.
- Each `DIVIDE` cycle, with a 25-bit remainder `r` (initialised to `ma`) and 24-bit `mb`:
  - if `r >= mb`: quotient bit = 1 and `r = r - mb`;
  - `r = r << 1`;
  - shift the bit into the 26-bit quotient `q`, MSB first.
- Normalisation:
  - If `q[25]` is set: mantissa = `q[25:2]`, guard = `q[1]`, sticky = `q[0] | (r != 0)`, exponent = `ea - eb + 127`.
  - Otherwise: mantissa = `q[24:1]`, guard = `q[0]`, sticky = `r != 0`, exponent = `ea - eb + 126`.
- Exponent arithmetic uses 10-bit signed values.
- Rounding (RNE): increment when `guard & (sticky | mantissa[0])`. If the increment carries out to 2.0, set the mantissa to 1.0 and add 1 to the exponent.
- Range checks, after rounding:
  - exponent ≥ 255 → signed infinity;
  - exponent ≤ 0 → signed zero (no denormal output).

## Timing
- Reset values: `result = 32'h00000000`, `done = 0`, state `IDLE`, counter 0.
- Latency:
  - Edge E samples `start`.
  - Edges E+1..E+26 run `DIVIDE`.
  - Edge E+27 runs `ROUND`: `result` and `done` register on this edge and the state moves to `DONE`.
  - `done` is therefore visible after 27 edges.
- `result` changes only on the `ROUND` edge. Between operations it holds the last quotient.
- `done` falls on the edge that accepts the next `start`. A back-to-back `start` while in `DONE` is legal, giving a throughput of one division per 28 cycles including the accept edge.
- `reset` asserted mid-`DIVIDE` forces `IDLE` immediately with `done = 0` and `result = 0`. The first `start` after deassertion behaves as from power-up.
- The `dataa`/`datab` ports may change freely after the `start` edge.

## Test plan
- Reset held 2 cycles, then `start` with `dataa = 32'h3fc00000`, `datab = 32'hbfc00000` → `done` is 0 for 26 edges, rises after edge 27, `result = 32'hbf800000`; `result`/`done` hold while `start` stays low.
- `start` with `32'h40400000` / `32'h40000000` → `32'h3fc00000`. Then `start` in the `DONE` state with `32'h3f800000` / `32'h40400000` → `done` drops immediately, then `32'h3eaaaaab` (round-up path).
- Special cases (each → expected result):
  - `32'h3f800000` / `32'h00000000` → `32'h7f800000`
  - `32'h00000000` / `32'h00000000` → `32'h7fc00000`
  - `32'h80000000` / `32'h40000000` → `32'h80000000`
  - `32'h7f800000` / `32'h7f800000` → `32'h7fc00000`
  - Every case must show the same 27-edge latency.
- Range limits:
  - `32'h7f000000` / `32'h3e800000` → `32'h7f800000` (overflow).
  - `32'h00800000` / `32'h40000000` → `32'h00000000` (underflow flush).
- Launch a division, pulse `start` with new operands during `DIVIDE`, then assert `reset` at edge 10 → the pulse is ignored, `done` stays 0, `result = 0`. A subsequent `start` with 3.0 / 2.0 completes normally.
- Randomised normal operands (both exponents in 64..190) compared against a real-arithmetic model rounded RNE → bit-exact match over 1000 operations.

Source files
------------

// File: rtl/fpdiv_if.sv
// Handshake and operand/result bus for the iterative binary32 divider.
// The master launches divisions; the slave (the divider) returns the quotient.
interface fpdiv_if;
    logic        start;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic [31:0] result;
    logic        done;

    modport master (
        output start,
        output dataa,
        output datab,
        input  result,
        input  done
    );

    modport slave (
        input  start,
        input  dataa,
        input  datab,
        output result,
        output done
    );
endinterface

// File: rtl/fpdiv.sv
// Iterative IEEE-754 binary32 divider.
// Restoring shift-subtract loop, one quotient bit per clock, round to nearest even.
// Fixed latency: 26 DIVIDE cycles plus one ROUND cycle after the accept edge,
// independent of the operand values (special operands run the full sequence too).
// Denormal inputs are flushed to zero and no denormal results are produced.
module fpdiv (
    input  logic   clk,
    input  logic   reset,
    fpdiv_if.slave bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DIVIDE = 2'd1;
    localparam logic [1:0] ST_ROUND  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [31:0] QNAN = 32'h7fc00000;

    // Operand classification: returns {special_flag, special_result}.
    // Priority: NaN (incl. 0/0, inf/inf), then signed infinity, then signed zero.
    function automatic logic [32:0] classify(input logic [31:0] a, input logic [31:0] b);
        logic a_zero;
        logic b_zero;
        logic a_inf;
        logic b_inf;
        logic a_nan;
        logic b_nan;
        logic sgn;
        logic [32:0] res;
        a_zero = (a[30:23] == 8'd0);
        b_zero = (b[30:23] == 8'd0);
        a_inf  = (a[30:23] == 8'hff) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hff) && (b[22:0] == 23'd0);
        a_nan  = (a[30:23] == 8'hff) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hff) && (b[22:0] != 23'd0);
        sgn    = a[31] ^ b[31];
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            res = {1'b1, QNAN};
        end else if (a_inf || b_zero) begin
            res = {1'b1, sgn, 8'hff, 23'd0};
        end else if (a_zero || b_inf) begin
            res = {1'b1, sgn, 31'd0};
        end else begin
            res = {1'b0, 32'd0};
        end
        return res;
    endfunction

    logic [1:0]        state_q,    state_d;
    logic [4:0]        cnt_q,      cnt_d;
    logic              sign_q,     sign_d;
    logic signed [9:0] exp_q,      exp_d;       // ea - eb + 126 (unnormalised)
    logic [24:0]       rem_q,      rem_d;
    logic [23:0]       mb_q,       mb_d;
    logic [25:0]       quo_q,      quo_d;
    logic              spec_q,     spec_d;
    logic [31:0]       spec_res_q, spec_res_d;
    logic [31:0]       result_q,   result_d;
    logic              done_q,     done_d;

    logic              ge_s;
    logic [24:0]       rem_sub_s;
    logic [24:0]       rem_next_s;
    logic [25:0]       quo_next_s;

    logic [23:0]       man_s;
    logic              guard_s;
    logic              sticky_s;
    logic              inc_s;
    logic [24:0]       man_rnd_s;
    logic [23:0]       man_fin_s;
    logic signed [9:0] exp_norm_s;
    logic signed [9:0] exp_fin_s;
    logic [31:0]       round_res_s;
    logic [32:0]       class_s;

    // One restoring divide step: compare, conditionally subtract, shift.
    always_comb begin
        ge_s       = (rem_q >= {1'b0, mb_q});
        if (ge_s) begin
            rem_sub_s = rem_q - {1'b0, mb_q};
        end else begin
            rem_sub_s = rem_q;
        end
        rem_next_s = rem_sub_s << 1;
        quo_next_s = {quo_q[24:0], ge_s};
    end

    // Normalise, round to nearest even, range-check and apply special override.
    always_comb begin
        if (quo_q[25]) begin
            man_s      = quo_q[25:2];
            guard_s    = quo_q[1];
            sticky_s   = quo_q[0] | (rem_q != 25'd0);
            exp_norm_s = exp_q + 10'sd1;
        end else begin
            man_s      = quo_q[24:1];
            guard_s    = quo_q[0];
            sticky_s   = (rem_q != 25'd0);
            exp_norm_s = exp_q;
        end
        inc_s     = guard_s & (sticky_s | man_s[0]);
        man_rnd_s = {1'b0, man_s} + {24'd0, inc_s};
        if (man_rnd_s[24]) begin
            // Rounding carried out to 2.0: renormalise to 1.0 at the next exponent.
            man_fin_s = 24'h800000;
            exp_fin_s = exp_norm_s + 10'sd1;
        end else begin
            man_fin_s = man_rnd_s[23:0];
            exp_fin_s = exp_norm_s;
        end
        if (spec_q) begin
            round_res_s = spec_res_q;
        end else if (exp_fin_s >= 10'sd255) begin
            round_res_s = {sign_q, 8'hff, 23'd0};
        end else if (exp_fin_s <= 10'sd0) begin
            round_res_s = {sign_q, 31'd0};
        end else begin
            round_res_s = {sign_q, exp_fin_s[7:0], man_fin_s[22:0]};
        end
    end

    // Controller next-state: launch, iterate, round, hold.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sign_d     = sign_q;
        exp_d      = exp_q;
        rem_d      = rem_q;
        mb_d       = mb_q;
        quo_d      = quo_q;
        spec_d     = spec_q;
        spec_res_d = spec_res_q;
        result_d   = result_q;
        done_d     = done_q;
        class_s    = classify(bus.dataa, bus.datab);
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    sign_d     = bus.dataa[31] ^ bus.datab[31];
                    exp_d      = $signed({2'b00, bus.dataa[30:23]})
                               - $signed({2'b00, bus.datab[30:23]}) + 10'sd126;
                    rem_d      = {1'b0, (bus.dataa[30:23] != 8'd0), bus.dataa[22:0]};
                    mb_d       = {(bus.datab[30:23] != 8'd0), bus.datab[22:0]};
                    quo_d      = 26'd0;
                    spec_d     = class_s[32];
                    spec_res_d = class_s[31:0];
                    cnt_d      = 5'd25;
                    done_d     = 1'b0;
                    state_d    = ST_DIVIDE;
                end else begin
                    state_d    = state_q;
                end
            end
            ST_DIVIDE: begin
                rem_d = rem_next_s;
                quo_d = quo_next_s;
                if (cnt_q == 5'd0) begin
                    state_d = ST_ROUND;
                end else begin
                    cnt_d   = cnt_q - 5'd1;
                end
            end
            ST_ROUND: begin
                result_d = round_res_s;
                done_d   = 1'b1;
                state_d  = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous abort to IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 5'd0;
            sign_q     <= 1'b0;
            exp_q      <= 10'sd0;
            rem_q      <= 25'd0;
            mb_q       <= 24'd0;
            quo_q      <= 26'd0;
            spec_q     <= 1'b0;
            spec_res_q <= 32'd0;
            result_q   <= 32'd0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sign_q     <= sign_d;
            exp_q      <= exp_d;
            rem_q      <= rem_d;
            mb_q       <= mb_d;
            quo_q      <= quo_d;
            spec_q     <= spec_d;
            spec_res_q <= spec_res_d;
            result_q   <= result_d;
            done_q     <= done_d;
        end
    end

    assign bus.result = result_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_fpdiv.sv
// Directed and randomised checks for the iterative binary32 divider.
module tb_fpdiv;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;
    int   edges;

    fpdiv_if bus ();

    fpdiv dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edges++;
    endtask

    // Present operands with start for one cycle; the accept edge is edge 0.
    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.dataa = a;
        bus.datab = b;
        @(posedge clk);
        #1;
        edges     = 0;
        bus.start = 1'b0;
        bus.dataa = $urandom;
        bus.datab = $urandom;
    endtask

    task automatic wait_done();
        while (!bus.done && edges < 40) tick();
    endtask

    // Reference quotient from real arithmetic, rounded to nearest even.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
        real x;
        real sc;
        real fr;
        int  e;
        int  m;
        logic s;
        s  = a[31] ^ b[31];
        x  = $itor({8'd0, 1'b1, a[22:0]}) / $itor({8'd0, 1'b1, b[22:0]});
        e  = int'(a[30:23]) - int'(b[30:23]) + 127;
        if (x < 1.0) begin
            x = x * 2.0;
            e = e - 1;
        end
        sc = x * 8388608.0;
        m  = $rtoi(sc);
        fr = sc - $itor(m);
        if (fr > 0.5 || (fr == 0.5 && m[0])) m = m + 1;
        if (m == 16777216) begin
            m = 8388608;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hff, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, e[7:0], m[22:0]};
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] hold_r;

        vecs[0]  = '{32'h3fc00000, 32'hbfc00000, 32'hbf800000};
        vecs[1]  = '{32'h40400000, 32'h40000000, 32'h3fc00000};
        vecs[2]  = '{32'h3f800000, 32'h40400000, 32'h3eaaaaab};
        vecs[3]  = '{32'h3f800000, 32'h00000000, 32'h7f800000};
        vecs[4]  = '{32'h00000000, 32'h00000000, 32'h7fc00000};
        vecs[5]  = '{32'h80000000, 32'h40000000, 32'h80000000};
        vecs[6]  = '{32'h7f800000, 32'h7f800000, 32'h7fc00000};
        vecs[7]  = '{32'h7f000000, 32'h3e800000, 32'h7f800000};
        vecs[8]  = '{32'h00800000, 32'h40000000, 32'h00000000};
        vecs[9]  = '{32'h7f800001, 32'h3f800000, 32'h7fc00000};
        vecs[10] = '{32'h7f800000, 32'hbf800000, 32'hff800000};
        vecs[11] = '{32'hc0000000, 32'h7f800000, 32'h80000000};
        vecs[12] = '{32'h00400000, 32'h3f800000, 32'h00000000};
        vecs[13] = '{32'h40000000, 32'h80000000, 32'hff800000};
        vecs[14] = '{32'h41200000, 32'h40a00000, 32'h40000000};
        vecs[15] = '{32'hc1100000, 32'h40400000, 32'hc0400000};
        vecs[16] = '{32'h3f800000, 32'h3f000000, 32'h40000000};
        vecs[17] = '{32'h3f800000, 32'h7fc00000, 32'h7fc00000};

        n_pass    = 0;
        n_total   = 0;
        edges     = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.dataa = 32'd0;
        bus.datab = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_result", bus.result, 32'h00000000);
        check("reset_done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // First division with explicit latency and hold checks.
        launch(32'h3fc00000, 32'hbfc00000);
        wait_done();
        check("first_latency", edges, 32'd27);
        check("first_result", bus.result, 32'hbf800000);
        repeat (5) tick();
        check("hold_result", bus.result, 32'hbf800000);
        check("hold_done", {31'd0, bus.done}, 32'd1);

        // Back-to-back start accepted in DONE: done falls on the accept edge.
        launch(32'h40400000, 32'h40000000);
        wait_done();
        check("b2b_first", bus.result, 32'h3fc00000);
        launch(32'h3f800000, 32'h40400000);
        check("b2b_done_drop", {31'd0, bus.done}, 32'd0);
        check("b2b_result_held", bus.result, 32'h3fc00000);
        wait_done();
        check("b2b_latency", edges, 32'd27);
        check("b2b_round_up", bus.result, 32'h3eaaaaab);

        // Table of directed vectors, each with latency check.
        for (int i = 0; i < 18; i++) begin
            launch(vecs[i].a, vecs[i].b);
            wait_done();
            check($sformatf("vec%0d_latency", i), edges, 32'd27);
            check($sformatf("vec%0d_result", i), bus.result, vecs[i].q);
        end

        // start during DIVIDE is ignored: original operands and timing survive.
        launch(32'h3f800000, 32'h40400000);
        repeat (4) tick();
        @(negedge clk);
        bus.start = 1'b1;
        bus.dataa = 32'h40400000;
        bus.datab = 32'h40000000;
        tick();
        bus.start = 1'b0;
        wait_done();
        check("ignored_start_latency", edges, 32'd27);
        check("ignored_start_result", bus.result, 32'h3eaaaaab);

        // Reset mid-DIVIDE aborts; next start behaves as from power-up.
        launch(32'h40400000, 32'h40000000);
        repeat (4) tick();
        @(negedge clk);
        bus.start = 1'b1;
        bus.dataa = 32'h3f800000;
        bus.datab = 32'h40400000;
        tick();
        bus.start = 1'b0;
        while (edges < 10) tick();
        reset = 1'b1;
        #1;
        check("abort_done", {31'd0, bus.done}, 32'd0);
        check("abort_result", bus.result, 32'h00000000);
        @(negedge clk);
        reset = 1'b0;
        repeat (30) tick();
        check("post_abort_done", {31'd0, bus.done}, 32'd0);
        check("post_abort_result", bus.result, 32'h00000000);
        launch(32'h40400000, 32'h40000000);
        wait_done();
        check("post_abort_latency", edges, 32'd27);
        check("post_abort_div", bus.result, 32'h3fc00000);

        // Randomised normal operands against the real-arithmetic reference.
        for (int k = 0; k < 1000; k++) begin
            ra = {1'($urandom), 8'($urandom_range(190, 64)), 23'($urandom)};
            rb = {1'($urandom), 8'($urandom_range(190, 64)), 23'($urandom)};
            launch(ra, rb);
            wait_done();
            hold_r = model(ra, rb);
            check($sformatf("rand%0d_%h_%h", k, ra, rb), bus.result, hold_r);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
